// File: rtl/seq_code_lock_pkg.sv
// seq_code_lock_pkg: lock FSM state encoding and timer width helper
package seq_code_lock_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ENTRY    = 2'd1,
        S_UNLOCKED = 2'd2,
        S_LOCKOUT  = 2'd3
    } state_e;

    // Bits needed to hold the largest of three cycle counts.
    function automatic int clog2_max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seq_code_lock_timer.sv
// seq_code_lock_timer: saturating up-counter with clear/enable and compare-equal done
module seq_code_lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign done_o = cnt_q == limit_i;

endmodule

// File: rtl/seq_code_lock.sv
// seq_code_lock: two-button sequence lock with reprogrammable code,
// per-digit entry timeout, timed unlock window and lockout after repeated failures
module seq_code_lock
    import seq_code_lock_pkg::*;
#(
    parameter int                  CODE_LEN    = 5,
    parameter logic [CODE_LEN-1:0] RESET_CODE  = 5'b01011,
    parameter int                  MAX_FAILS   = 3,
    parameter int                  TIMEOUT_CYC = 1000,
    parameter int                  UNLOCK_CYC  = 500,
    parameter int                  LOCKOUT_CYC = 5000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             button0,
    input  logic                             button1,
    input  logic                             prog_en,
    input  logic [CODE_LEN-1:0]              prog_code,
    output logic                             unlock,
    output logic                             locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int TW = clog2_max3(TIMEOUT_CYC, UNLOCK_CYC, LOCKOUT_CYC);

    state_e              state_q, state_d;
    logic [CODE_LEN-2:0] shift_q, shift_d;
    logic [CW-1:0]       dcnt_q, dcnt_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [FW-1:0]       fail_q, fail_d;
    logic                unlock_q, locked_q;
    logic                valid, restart, t_done;
    logic [CODE_LEN-1:0] entered;
    logic [FW-1:0]       fail_inc;
    logic [TW-1:0]       limit;

    assign valid    = button0 ^ button1;
    assign entered  = {shift_q, button1};
    assign fail_inc = fail_q + FW'(1);
    // Timer done fires on the last cycle of the window, so each limit is one less.
    assign limit    = state_q == S_ENTRY    ? TW'(TIMEOUT_CYC - 1) :
                      state_q == S_UNLOCKED ? TW'(UNLOCK_CYC - 1)  : TW'(LOCKOUT_CYC - 1);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        dcnt_d  = dcnt_q;
        code_d  = code_q;
        fail_d  = fail_q;
        restart = 1'b0;
        case (state_q)
            S_IDLE: if (valid) begin
                state_d = S_ENTRY;
                shift_d = (CODE_LEN-1)'(button1);
                dcnt_d  = CW'(1);
            end
            S_ENTRY: if (valid) begin
                restart = 1'b1;
                shift_d = entered[CODE_LEN-2:0];
                dcnt_d  = dcnt_q + CW'(1);
                if (dcnt_q == CW'(CODE_LEN - 1)) begin
                    if (entered == code_q) begin
                        state_d = S_UNLOCKED;
                        fail_d  = '0;
                    end else if (fail_inc == FW'(MAX_FAILS)) begin
                        state_d = S_LOCKOUT;
                        fail_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        fail_d  = fail_inc;
                    end
                end
            end else if (t_done) begin
                state_d = S_IDLE;
            end
            S_UNLOCKED: if (prog_en) begin
                code_d  = prog_code;
                restart = 1'b1;
            end else if (valid || t_done) begin
                state_d = S_IDLE;
            end
            S_LOCKOUT: if (t_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    seq_code_lock_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (restart || state_d != state_q),
        .en_i   (state_q != S_IDLE),
        .limit_i(limit),
        .done_o (t_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            dcnt_q   <= '0;
            code_q   <= RESET_CODE;
            fail_q   <= '0;
            unlock_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            dcnt_q   <= dcnt_d;
            code_q   <= code_d;
            fail_q   <= fail_d;
            unlock_q <= state_d == S_UNLOCKED;
            locked_q <= state_d == S_LOCKOUT;
        end
    end

    assign unlock     = unlock_q;
    assign locked_out = locked_q;
    assign fail_cnt   = fail_q;

endmodule
